// File: rtl/data_memory_ctrl_if.sv
// Request/done handshake bundle between the CPU memory stage and data_memory_ctrl.
interface data_memory_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        ready;
  logic        done;
  logic [31:0] dataout;
  logic        fault;

  modport master (
    output req, we, size, unsigned_ld, address, writeData,
    input  ready, done, dataout, fault
  );

  modport slave (
    input  req, we, size, unsigned_ld, address, writeData,
    output ready, done, dataout, fault
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressable big-endian data memory with wait states and a request/done handshake.
// Optional alignment/bounds faulting is compiled in with `define DMEM_BOUNDS_CHECK_EN.
//
// state    | meaning
// S_IDLE   | ready=1, accepts req and latches the access
// S_WAIT   | wait-state down-counter running to terminal count 0
// S_ACCESS | single cycle: read/write memory, raise done on exit
module data_memory_ctrl #(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 0
) (
  input logic               CLK,
  input logic               RST_N,
  data_memory_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        done_q;
  logic        fault_q;
  logic [31:0] dout_q;
  logic [31:0] dout_d;

  logic [7:0]  mem_q [DEPTH];

  logic [AW-1:0] i0, i1, i2, i3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   ld_data;
  logic          sx;
  logic          acc_fault;
  logic          wr_en;

  // Byte indices wrap naturally in AW bits.
  assign i0 = addr_q[AW-1:0];
  assign i1 = i0 + AW'(1);
  assign i2 = i0 + AW'(2);
  assign i3 = i0 + AW'(3);

  assign b0 = mem_q[i0];
  assign b1 = mem_q[i1];
  assign b2 = mem_q[i2];
  assign b3 = mem_q[i3];

  always_comb begin
    ld_data = {b0, b1, b2, b3};
    sx      = 1'b0;
    case (size_q)
      2'b00: begin
        sx      = ~uns_q & b0[7];
        ld_data = {{24{sx}}, b0};
      end
      2'b01: begin
        sx      = ~uns_q & b0[7];
        ld_data = {{16{sx}}, b0, b1};
      end
      default: ld_data = {b0, b1, b2, b3};
    endcase
  end

`ifdef DMEM_BOUNDS_CHECK_EN
  always_comb begin
    acc_fault = (addr_q >= 32'(DEPTH));
    case (size_q)
      2'b01:   if (addr_q[0]) acc_fault = 1'b1;
      2'b10:   if (addr_q[1:0] != 2'b00) acc_fault = 1'b1;
      2'b11:   acc_fault = 1'b1;
      default: ;
    endcase
  end
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_q[31:AW];
  assign acc_fault      = 1'b0;
`endif

  assign dout_d = acc_fault ? 32'h0 : ld_data;

  // RST_N gating drops a store whose commit edge coincides with reset.
  assign wr_en = RST_N && (state_q == S_ACCESS) && we_q && !acc_fault;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      case (size_q)
        2'b00: mem_q[i0] <= wdata_q[7:0];
        2'b01: begin
          mem_q[i0] <= wdata_q[15:8];
          mem_q[i1] <= wdata_q[7:0];
        end
        default: begin
          mem_q[i0] <= wdata_q[31:24];
          mem_q[i1] <= wdata_q[23:16];
          mem_q[i2] <= wdata_q[15:8];
          mem_q[i3] <= wdata_q[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      dout_q  <= 32'h0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            uns_q   <= bus.unsigned_ld;
            size_q  <= bus.size;
            addr_q  <= bus.address;
            wdata_q <= bus.writeData;
            ready_q <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(WAIT_CYCLES - 1);
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) state_q <= S_ACCESS;
          else               cnt_q   <= cnt_q - 4'd1;
        end
        S_ACCESS: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
          fault_q <= acc_fault;
          if (!we_q) dout_q <= dout_d;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready   = ready_q;
  assign bus.done    = done_q;
  assign bus.fault   = fault_q;
  assign bus.dataout = dout_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: three instances (0, 3 and 2 wait states) share clock and reset.
module tb_data_memory_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        req_s  [3];
  logic        we_s   [3];
  logic [1:0]  size_s [3];
  logic        uns_s  [3];
  logic [31:0] addr_s [3];
  logic [31:0] wd_s   [3];
  logic        rdy_s  [3];
  logic        done_s [3];
  logic        flt_s  [3];
  logic [31:0] dout_s [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int W = (g == 1) ? 3 : ((g == 2) ? 2 : 0);
      data_memory_ctrl_if bus ();
      assign bus.req         = req_s[g];
      assign bus.we          = we_s[g];
      assign bus.size        = size_s[g];
      assign bus.unsigned_ld = uns_s[g];
      assign bus.address     = addr_s[g];
      assign bus.writeData   = wd_s[g];
      assign rdy_s[g]        = bus.ready;
      assign done_s[g]       = bus.done;
      assign flt_s[g]        = bus.fault;
      assign dout_s[g]       = bus.dataout;
      data_memory_ctrl #(.DEPTH(128), .WAIT_CYCLES(W)) u_dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus.slave)
      );
    end
  endgenerate

  typedef struct {
    int          inst;
    int          tag;
    logic [31:0] data;
    logic        flt;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          tagc = 0;
  int          last_done [3];
  logic [31:0] last_ld [3];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wt(input int k);
    return (k == 1) ? 3 : ((k == 2) ? 2 : 0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", nm, act, exp);
    end
  endtask

  task automatic expire(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired, got no event, expected one", nm);
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy_s[k] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (rdy_s[k] !== 1'b1) expire("ready_wait");
  endtask

  task automatic access(input int k, input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ef);
    exp_t e;
    wait_ready(k);
    req_s[k]  = 1'b1;
    we_s[k]   = we;
    size_s[k] = sz;
    uns_s[k]  = uns;
    addr_s[k] = a;
    wd_s[k]   = wd;
    @(posedge clk);
    #1;
    e.inst = k;
    e.tag  = tagc;
    e.flt  = ef;
    e.acc  = cyc;
    tagc++;
    if (we) e.data = last_ld[k];
    else begin
      e.data     = ed;
      last_ld[k] = ed;
    end
    sb.push_back(e);
    // Scramble inputs after acceptance: the DUT must use its latched copy.
    req_s[k]  = 1'b0;
    we_s[k]   = ~we;
    size_s[k] = ~sz;
    uns_s[k]  = ~uns;
    addr_s[k] = ~a;
    wd_s[k]   = ~wd;
  endtask

  task automatic st(input int k, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] wd, input logic ef);
    access(k, 1'b1, sz, 1'b0, a, wd, 32'h0, ef);
  endtask

  task automatic ld(input int k, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                    input logic [31:0] ed, input logic ef);
    access(k, 1'b0, sz, uns, a, 32'h0, ed, ef);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) expire("drain_done");
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done_s[k] === 1'b1) begin
        last_done[k] = cyc;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: inst %0d got done=1, expected no pending access", k);
        end else begin
          mon_e = sb.pop_front();
          chk($sformatf("t%0d_inst", mon_e.tag), 32'(k), 32'(mon_e.inst));
          chk($sformatf("t%0d_latency", mon_e.tag), 32'(cyc - mon_e.acc), 32'(wt(k) + 1));
          chk($sformatf("t%0d_dataout", mon_e.tag), dout_s[k], mon_e.data);
          chk($sformatf("t%0d_fault", mon_e.tag), 32'(flt_s[k]), 32'(mon_e.flt));
          chk($sformatf("t%0d_ready_in_done", mon_e.tag), 32'(rdy_s[k]), 32'd1);
        end
      end
    end
  end

  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_R = 2'b11;

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_s[k]     = 1'b0;
      we_s[k]      = 1'b0;
      size_s[k]    = 2'b00;
      uns_s[k]     = 1'b0;
      addr_s[k]    = 32'h0;
      wd_s[k]      = 32'h0;
      last_ld[k]   = 32'h0;
      last_done[k] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(rdy_s[k]), 32'd1);
      chk("rst_done", 32'(done_s[k]), 32'd0);
      chk("rst_fault", 32'(flt_s[k]), 32'd0);
      chk("rst_dataout", dout_s[k], 32'h0);
    end
    rst_n = 1'b1;

    // No wait states: round trip, extension, partial stores, fault/wrap cases.
    st(0, SZ_W, 32'd8, 32'h11223344, 1'b0);
    ld(0, SZ_W, 1'b0, 32'd8, 32'h11223344, 1'b0);
    ld(0, SZ_B, 1'b0, 32'd8, 32'h00000011, 1'b0);
    ld(0, SZ_B, 1'b0, 32'd11, 32'h00000044, 1'b0);
    st(0, SZ_B, 32'd5, 32'h00000080, 1'b0);
    ld(0, SZ_B, 1'b0, 32'd5, 32'hFFFFFF80, 1'b0);
    ld(0, SZ_B, 1'b1, 32'd5, 32'h00000080, 1'b0);
    st(0, SZ_H, 32'd6, 32'h00008001, 1'b0);
    ld(0, SZ_H, 1'b0, 32'd6, 32'hFFFF8001, 1'b0);
    ld(0, SZ_H, 1'b1, 32'd6, 32'h00008001, 1'b0);
    st(0, SZ_W, 32'd0, 32'hAABBCCDD, 1'b0);
    st(0, SZ_H, 32'd2, 32'h00001234, 1'b0);
    ld(0, SZ_W, 1'b0, 32'd0, 32'hAABB1234, 1'b0);
    ld(0, SZ_W, 1'b0, 32'd6, CHK ? 32'h0 : 32'h80011122, CHK);
    ld(0, SZ_H, 1'b0, 32'd9, CHK ? 32'h0 : 32'h00002233, CHK);
    ld(0, SZ_R, 1'b0, 32'd8, CHK ? 32'h0 : 32'h11223344, CHK);
    st(0, SZ_W, 32'd4, 32'h55667788, 1'b0);
    st(0, SZ_W, 32'd132, 32'h99999999, CHK);
    ld(0, SZ_W, 1'b0, 32'd4, CHK ? 32'h55667788 : 32'h99999999, CHK ? 1'b0 : 1'b0);

    // Three wait states: busy-cycle req ignored, then back-to-back loads.
    st(1, SZ_W, 32'd8, 32'h0A0B0C0D, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("busy_ready", 32'(rdy_s[1]), 32'd0);
      req_s[1]  = 1'b1;
      we_s[1]   = 1'b1;
      size_s[1] = SZ_W;
      addr_s[1] = 32'd8;
      wd_s[1]   = 32'hFFFFFFFF;
    end
    @(negedge clk);
    chk("busy_ready", 32'(rdy_s[1]), 32'd0);
    req_s[1] = 1'b0;
    ld(1, SZ_W, 1'b0, 32'd8, 32'h0A0B0C0D, 1'b0);
    chk("b2b_gap1", 32'(cyc - last_done[1]), 32'd1);
    ld(1, SZ_B, 1'b0, 32'd9, 32'h0000000B, 1'b0);
    chk("b2b_gap2", 32'(cyc - last_done[1]), 32'd1);

    // Two wait states: reset during an in-flight store drops it.
    st(2, SZ_W, 32'd16, 32'hCAFEF00D, 1'b0);
    drain();
    wait_ready(2);
    req_s[2]  = 1'b1;
    we_s[2]   = 1'b1;
    size_s[2] = SZ_W;
    uns_s[2]  = 1'b0;
    addr_s[2] = 32'd16;
    wd_s[2]   = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_s[2] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) last_ld[k] = 32'h0;
    @(negedge clk);
    chk("midrst_ready", 32'(rdy_s[2]), 32'd1);
    chk("midrst_done", 32'(done_s[2]), 32'd0);
    chk("midrst_fault", 32'(flt_s[2]), 32'd0);
    chk("midrst_dataout", dout_s[2], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ld(2, SZ_W, 1'b0, 32'd16, 32'hCAFEF00D, 1'b0);

    drain();
    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
